riscv_i32_fetch_data_buffer: RTL
================================

Name: riscv_i32_fetch_data_buffer

Overview:
Parametrised successor to the combinational fetch-data stage. It pairs each accepted ifetch request with its response and queues the result in a DEPTH-entry FIFO, so decode can stall without stalling fetch. It discards stale responses by tag, flushes on a pipeline-control flush action, and presents registered fetch data to decode with a valid/ready handshake.

Parameters:
DEPTH, 2, number of buffered fetch entries; power of 2, range 2..8
TAG_WIDTH, 2, width of the ifetch response and pipeline-control tag

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous reset, active-high
ifetch_req__valid  input  1  fetch request issued this cycle
ifetch_req__address  input  32  PC of the request
ifetch_req__predicted_branch  input  1  request is a predicted-taken target
ifetch_req__pc_if_mispredicted  input  32  recovery PC
ifetch_req__flush_pipeline  input  1  request marks a pipeline flush point
ifetch_resp__valid  input  1  response data valid
ifetch_resp__data  input  32  instruction word
ifetch_resp__error  input  1  fetch access fault
ifetch_resp__tag  input  TAG_WIDTH  tag of the response
pipeline_control__valid  input  1  control word valid
pipeline_control__fetch_action  input  2  0 none, 1 continue, 2 restart, 3 flush
pipeline_control__tag  input  TAG_WIDTH  current expected tag
fetch_ready  output  1  buffer can accept an entry this cycle
decode_ready  input  1  decode consumes the head entry this cycle
pipeline_fetch_data__valid  output  1  head entry valid
pipeline_fetch_data__pc  output  32  head PC
pipeline_fetch_data__data  output  32  head instruction
pipeline_fetch_data__error  output  1  head fetch fault
pipeline_fetch_data__dec_flush_pipeline  output  1  head flush marker
pipeline_fetch_data__dec_predicted_branch  output  1  head prediction flag
pipeline_fetch_data__dec_pc_if_mispredicted  output  32  head recovery PC
occupancy  output  clog2(DEPTH)+1  entries held

Behaviour:
- Reset is synchronous and active-high. It clears the read/write pointers. In the cycle after reset: pipeline_fetch_data__valid=0, occupancy=0, fetch_ready=1, and all data outputs are 0 (payload registers are reset).
- fetch_ready = (occupancy != DEPTH). It is registered state only and has no combinational path from decode_ready.
- flush = pipeline_control__valid & (fetch_action==3).
- push = ifetch_req__valid & ifetch_resp__valid & pipeline_control__valid & ifetch_resp__tag==pipeline_control__tag & fetch_ready & !flush.
- A tag mismatch drops the response silently; occupancy is unchanged.
- pop = pipeline_fetch_data__valid & decode_ready.
- Payload of an entry is {address, data, error, flush_pipeline, predicted_branch, pc_if_mispredicted}.
- Latency: an entry pushed at edge N is visible on pipeline_fetch_data__* after edge N. There is no combinational input-to-output path.
- The outputs always show the head entry; pipeline_fetch_data__valid = (occupancy != 0).
- Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full means the MSBs differ and the low bits are equal.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. This is legal when empty+push (no pop, since valid=0) and when full+pop (no push, since fetch_ready=0).
- Flush: at the next edge both pointers are set equal (empty). Any concurrent push is dropped and any pop is ignored. Flush takes priority over everything except reset.
- fetch_action 0/1/2 does not alter buffer contents. Restart relies on the tag change to drop stale data.
- A response with error=1 is buffered like any other entry. Its data value is passed through unmodified.
- Reset asserted mid-stream empties the buffer; contents are discarded and no output is produced.
- Assertion: push never occurs while full; pop never occurs while empty.

Decomposition:
- Package riscv_i32_fetch_pkg holds:
  - fetch_action encodings (FA_NONE=0, FA_CONTINUE=1, FA_RESTART=2, FA_FLUSH=3);
  - the fetch buffer entry struct (payload above);
  - the ifetch_req, ifetch_resp, pipeline_control and pipeline_fetch_data struct types.
- One sub-module, riscv_fetch_fifo: a generic synchronous FIFO with DEPTH/WIDTH parameters, push/pop/flush inputs, and full/empty/occupancy/head outputs.
- The top level contains the tag filter, the push/pop/flush logic and the payload packing.

Test Plan:
- Reset, then idle → valid=0, fetch_ready=1, occupancy=0. Then push pc=0x100, data=0x00000013 at cycle 1 → next cycle valid=1, pc=0x100, data=0x13.
- decode_ready=0, push 3 entries with DEPTH=2 → occupancy=2, fetch_ready=0, third push rejected; the third request is not buffered.
- Full buffer, decode_ready=1 for 2 cycles → outputs in order pc 0x100 then 0x104; occupancy 2→1→0; fetch_ready=1 after the first pop.
- pipeline_control__tag=1, response tag=0 with all valids high → no push, occupancy stays 0. Then tag=1 → push.
- Occupancy 2 plus flush concurrent with a valid push and decode_ready=1 → next cycle occupancy=0, valid=0, pushed entry lost.
- Steady stream with push and pop every cycle over 20 cycles → occupancy constant at 1. Pointers wrap past 2*DEPTH and PCs 0x0,0x4,… emerge in order with no gaps or duplicates. Error=1 on one entry propagates with the matching pc.

Source files
------------

// File: rtl/riscv_i32_fetch_pkg.sv
// Shared types for the ifetch-to-decode buffer.
// Fetch actions, request/response/control bundles and the buffered entry.
package riscv_i32_fetch_pkg;

  localparam int TAG_MAX = 8;

  typedef enum logic [1:0] {
    FA_NONE     = 2'd0,
    FA_CONTINUE = 2'd1,
    FA_RESTART  = 2'd2,
    FA_FLUSH    = 2'd3
  } fetch_action_e;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic        error;
    logic        flush_pipeline;
    logic        predicted_branch;
    logic [31:0] pc_if_mispredicted;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic        predicted_branch;
    logic [31:0] pc_if_mispredicted;
    logic        flush_pipeline;
  } ifetch_req_t;

  typedef struct packed {
    logic               valid;
    logic [31:0]        data;
    logic               error;
    logic [TAG_MAX-1:0] tag;
  } ifetch_resp_t;

  typedef struct packed {
    logic               valid;
    fetch_action_e      fetch_action;
    logic [TAG_MAX-1:0] tag;
  } pipeline_control_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
    logic        error;
    logic        dec_flush_pipeline;
    logic        dec_predicted_branch;
    logic [31:0] dec_pc_if_mispredicted;
  } pipeline_fetch_data_t;

endpackage

// File: rtl/riscv_i32_fetch_data_buffer_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits, flush empties it.
// Ports: push/pop/flush/push_data in; full/empty/occupancy/head out.
module riscv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Extra pointer bit separates full from empty.
  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];

  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/riscv_i32_fetch_data_buffer.sv
// Pairs ifetch requests with tagged responses and queues them for decode.
// Ports: ifetch_req/resp, pipeline_control in; fetch_ready, fetch data, occupancy out.
module riscv_i32_fetch_data_buffer
  import riscv_i32_fetch_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifetch_req__valid,
  input  logic [31:0]            ifetch_req__address,
  input  logic                   ifetch_req__predicted_branch,
  input  logic [31:0]            ifetch_req__pc_if_mispredicted,
  input  logic                   ifetch_req__flush_pipeline,
  input  logic                   ifetch_resp__valid,
  input  logic [31:0]            ifetch_resp__data,
  input  logic                   ifetch_resp__error,
  input  logic [TAG_WIDTH-1:0]   ifetch_resp__tag,
  input  logic                   pipeline_control__valid,
  input  logic [1:0]             pipeline_control__fetch_action,
  input  logic [TAG_WIDTH-1:0]   pipeline_control__tag,
  output logic                   fetch_ready,
  input  logic                   decode_ready,
  output logic                   pipeline_fetch_data__valid,
  output logic [31:0]            pipeline_fetch_data__pc,
  output logic [31:0]            pipeline_fetch_data__data,
  output logic                   pipeline_fetch_data__error,
  output logic                   pipeline_fetch_data__dec_flush_pipeline,
  output logic                   pipeline_fetch_data__dec_predicted_branch,
  output logic [31:0]            pipeline_fetch_data__dec_pc_if_mispredicted,
  output logic [$clog2(DEPTH):0] occupancy
);

  ifetch_req_t          req;
  ifetch_resp_t         resp;
  pipeline_control_t    ctl;
  pipeline_fetch_data_t fd;
  fetch_entry_t         in_entry;
  fetch_entry_t         head;
  logic                 full;
  logic                 empty;
  logic                 flush;
  logic                 tag_ok;
  logic                 push;
  logic                 pop;

  assign req = '{
    valid:              ifetch_req__valid,
    address:            ifetch_req__address,
    predicted_branch:   ifetch_req__predicted_branch,
    pc_if_mispredicted: ifetch_req__pc_if_mispredicted,
    flush_pipeline:     ifetch_req__flush_pipeline
  };

  assign resp = '{
    valid: ifetch_resp__valid,
    data:  ifetch_resp__data,
    error: ifetch_resp__error,
    tag:   TAG_MAX'(ifetch_resp__tag)
  };

  assign ctl = '{
    valid:        pipeline_control__valid,
    fetch_action: fetch_action_e'(pipeline_control__fetch_action),
    tag:          TAG_MAX'(pipeline_control__tag)
  };

  assign flush  = ctl.valid && (ctl.fetch_action == FA_FLUSH);
  // Responses from before a restart carry an old tag and fall away here.
  assign tag_ok = (resp.tag == ctl.tag);
  assign fetch_ready = !full;
  assign push = req.valid && resp.valid && ctl.valid &&
                tag_ok && fetch_ready && !flush;
  assign pop  = fd.valid && decode_ready;

  assign in_entry = '{
    address:            req.address,
    data:               resp.data,
    error:              resp.error,
    flush_pipeline:     req.flush_pipeline,
    predicted_branch:   req.predicted_branch,
    pc_if_mispredicted: req.pc_if_mispredicted
  };

  riscv_fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (in_entry),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy),
    .head      (head)
  );

  assign fd = '{
    valid:                  !empty,
    pc:                     head.address,
    data:                   head.data,
    error:                  head.error,
    dec_flush_pipeline:     head.flush_pipeline,
    dec_predicted_branch:   head.predicted_branch,
    dec_pc_if_mispredicted: head.pc_if_mispredicted
  };

  assign pipeline_fetch_data__valid                  = fd.valid;
  assign pipeline_fetch_data__pc                     = fd.pc;
  assign pipeline_fetch_data__data                   = fd.data;
  assign pipeline_fetch_data__error                  = fd.error;
  assign pipeline_fetch_data__dec_flush_pipeline     = fd.dec_flush_pipeline;
  assign pipeline_fetch_data__dec_predicted_branch   = fd.dec_predicted_branch;
  assign pipeline_fetch_data__dec_pc_if_mispredicted = fd.dec_pc_if_mispredicted;

endmodule
